i2s_rx: RTL and testbench

- I2S slave receiver. Deserialises an external I2S stream (bclk/lrclk/data driven by a codec or by the soc transmitter in loopback benches) into left/right sample pairs.
- Oversamples all three pins in the `clk` domain, aligns on the left channel, and buffers frames in a small FIFO.
- Frames are presented on a valid/ready stream for the core or DMA.

---
 rtl/i2s_pkg.sv | 7 +
 rtl/i2s_rx_fifo.sv | 38 +++
 rtl/i2s_rx.sv | 110 +++++++++++
 tb/tb_i2s_rx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared FSM encoding, channel ids and clock-ratio constant for the I2S receiver
package i2s_pkg;
   typedef enum logic [1:0] {IDLE, SEEK, LEFT, RIGHT} state_t;
   localparam logic CH_LEFT = 1'b0;
   localparam logic CH_RIGHT = 1'b1;
   localparam int MIN_CLK_BCLK_RATIO = 4;
endpackage

// File: rtl/i2s_rx_fifo.sv
// i2s_rx_fifo: synchronous frame FIFO with flush; a push when full is accepted only alongside a pop
module i2s_rx_fifo #(
   parameter int W = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW:0] wp, rp;
   logic wr, rd;
   assign empty = wp == rp;
   assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign rd = pop && !empty;
   assign wr = push && (!full || rd);
   assign dout = mem[rp[AW-1:0]];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else if (flush) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (wr) wp <= wp + 1'b1;
         if (rd) rp <= rp + 1'b1;
      end
   always_ff @(posedge clk)
      if (wr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S slave receiver into a frame FIFO; overflow/frame_err live only with I2S_RX_STATUS_EN
module i2s_rx
   import i2s_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             io_i2s_bclk,
   input  logic             io_i2s_lrclk,
   input  logic             io_i2s_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_left,
   output logic [WIDTH-1:0] out_right,
   output logic             overflow,
   output logic             frame_err
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] W_C = CW'(WIDTH);
   logic [2:0] pins, syn;
   assign pins = {io_i2s_bclk, io_i2s_lrclk, io_i2s_data};
   for (genvar g = 0; g < 3; g++) begin : g_sync
      logic [SYNC_STAGES-1:0] sr;
      always_ff @(posedge clk or posedge rst)
         if (rst) sr <= '0;
         else sr <= {sr[SYNC_STAGES-2:0], pins[g]};
      assign syn[g] = sr[SYNC_STAGES-1];
   end
   state_t state, state_nxt;
   logic bclk_q, lr_q, rise, lr_s, d_s, lr_chg, close, push_q, push, pop, full, empty;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] sh, sh_nxt, closed, left_q;
   logic [2*WIDTH-1:0] frame_q, head;
   assign lr_s = syn[1];
   assign d_s = syn[0];
   assign rise = syn[2] && !bclk_q;
   assign lr_chg = rise && (lr_s != lr_q);
   assign cnt_nxt = (cnt < W_C) ? cnt + 1'b1 : cnt;
   assign sh_nxt = (cnt < W_C) ? {sh[WIDTH-2:0], d_s} : sh;
   // short channels are left-justified: the captured bits become the MSBs
   assign closed = sh_nxt << (W_C - cnt_nxt);
   assign close = lr_chg && (state == LEFT || state == RIGHT);
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      state_nxt = !enable ? IDLE :
                  state == IDLE ? SEEK :
                  (lr_chg && lr_s == CH_LEFT && state != LEFT) ? LEFT :
                  (lr_chg && lr_s == CH_RIGHT && state == LEFT) ? RIGHT : state;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bclk_q <= 1'b0;
         lr_q <= 1'b0;
         cnt <= '0;
         sh <= '0;
         left_q <= '0;
         push_q <= 1'b0;
         frame_q <= '0;
      end else begin
         bclk_q <= syn[2];
         push_q <= 1'b0;
         if (!enable || state == IDLE) begin
            lr_q <= 1'b0;
            cnt <= '0;
            sh <= '0;
         end else if (rise) begin
            lr_q <= lr_s;
            cnt <= (close || state == SEEK) ? '0 : cnt_nxt;
            sh <= (close || state == SEEK) ? '0 : sh_nxt;
            if (close && state == LEFT) left_q <= closed;
            if (close && state == RIGHT) begin
               push_q <= 1'b1;
               frame_q <= {left_q, closed};
            end
         end
      end
   assign push = push_q && enable;
   assign pop = out_valid && out_ready;
   i2s_rx_fifo #(.W(2 * WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .flush(!enable), .push(push), .pop(pop),
      .din(frame_q), .dout(head), .full(full), .empty(empty)
   );
   assign out_valid = !empty;
   assign {out_left, out_right} = out_valid ? head : '0;
`ifdef I2S_RX_STATUS_EN
   logic ovf_q, ferr_q, short_ch;
   assign short_ch = cnt_nxt < W_C;
   always_ff @(posedge clk or posedge rst)
      if (rst) ovf_q <= 1'b0;
      else if (!enable) ovf_q <= 1'b0;
      else if (push && full && !pop) ovf_q <= 1'b1;
   always_ff @(posedge clk or posedge rst)
      if (rst) ferr_q <= 1'b0;
      else ferr_q <= enable && close && short_ch;
   assign overflow = ovf_q;
   assign frame_err = ferr_q;
`else
   logic unused_full;
   assign unused_full = full;
   assign overflow = 1'b0;
   assign frame_err = 1'b0;
`endif
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: randomized I2S stream against a slot-level frame model and scoreboard
module tb_i2s_rx;
`ifdef I2S_RX_STATUS_EN
   localparam bit STATUS = 1'b1;
`else
   localparam bit STATUS = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
   logic bclk = 1'b0, lrclk = 1'b0, data = 1'b0, out_ready = 1'b0;
   logic out_valid, overflow, frame_err;
   logic [15:0] out_left, out_right;
   int tests = 0, fails = 0, ferr_cnt = 0, ferr_exp = 0, ready_mode = 0;
   logic pend = 1'b0;
   logic [31:0] exp_q[$];
   i2s_rx #(.WIDTH(16), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .io_i2s_bclk(bclk), .io_i2s_lrclk(lrclk), .io_i2s_data(data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_left(out_left), .out_right(out_right),
      .overflow(overflow), .frame_err(frame_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // slot value as the receiver should keep it: first 16 bits, zero-padded when short
   function automatic logic [15:0] exp_val(input logic [63:0] v, input int n);
      logic [63:0] t;
      t = (n >= 16) ? (v >> (n - 16)) : (v << (16 - n));
      return t[15:0];
   endfunction
   // data lags lrclk by one bit clock, as in standard I2S
   task automatic send_bit(input logic lr, input logic d);
      @(negedge clk);
      bclk = 1'b0;
      lrclk = lr;
      data = pend;
      pend = d;
      repeat (4) @(negedge clk);
      bclk = 1'b1;
      repeat (3) @(negedge clk);
   endtask
   task automatic send_slot(input logic lr, input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(lr, v[i]);
   endtask
   task automatic send_frame(input logic [63:0] lv, input int ln, input logic [63:0] rv, input int rn, input bit keep);
      send_slot(1'b0, lv, ln);
      send_slot(1'b1, rv, rn);
      if (keep) begin
         exp_q.push_back({exp_val(lv, ln), exp_val(rv, rn)});
         ferr_exp += int'(ln < 16) + int'(rn < 16);
      end
   endtask
   task automatic start_group(input int mode);
      ready_mode = mode;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      enable = 1'b1;
      repeat (4) send_bit(1'b1, 1'b0);
   endtask
   task automatic wait_drain(input string tag);
      for (int i = 0; i < 4000 && exp_q.size() > 0; i++) @(negedge clk);
      chk(tag, exp_q.size(), 0);
   endtask
   task automatic end_group(input string tag);
      send_bit(1'b0, 1'b0);
      wait_drain(tag);
      repeat (4) @(negedge clk);
      chk({tag, "_ferr"}, ferr_cnt, STATUS ? ferr_exp : 0);
   endtask
   initial forever begin
      @(posedge clk);
      #2;
      out_ready = (ready_mode == 2) ? 1'($urandom % 2) : (ready_mode == 1);
   end
   always @(negedge clk) if (!rst) begin
      logic [31:0] e;
      if (frame_err) ferr_cnt++;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("extra_beat", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("left", out_left, e[31:16]);
            chk("right", out_right, e[15:0]);
         end
      end
   end
   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
   initial begin
      logic [63:0] lv, rv;
      int ln, rn;
      #23;
      chk("rst_valid", out_valid, 0);
      chk("rst_left", out_left, 0);
      chk("rst_right", out_right, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_ferr", frame_err, 0);
      @(negedge clk);
      rst = 1'b0;
      start_group(1);
      send_frame(64'hA5C3, 16, 64'h1234, 16, 1);
      end_group("basic");
      start_group(1);
      send_frame(64'hDEADBEEF, 32, 64'h0BADF00D, 32, 1);
      end_group("wide");
      start_group(1);
      send_frame(64'h5A, 8, 64'h00FF, 16, 1);
      end_group("short");
      start_group(2);
      for (int k = 0; k < 12; k++) begin
         ln = $urandom_range(8, 36);
         rn = $urandom_range(8, 36);
         lv = {$urandom, $urandom} & ((64'd1 << ln) - 1);
         rv = {$urandom, $urandom} & ((64'd1 << rn) - 1);
         send_frame(lv, ln, rv, rn, 1);
      end
      end_group("random");
      ready_mode = 1;
      enable = 1'b0;
      repeat (2) send_bit(1'b1, 1'b0);
      enable = 1'b1;
      repeat (4) send_bit(1'b1, 1'b1);
      send_frame(64'h1, 16, 64'h2, 16, 1);
      send_frame(64'h3, 16, 64'h4, 16, 1);
      end_group("align");
      start_group(0);
      for (int n = 1; n <= 5; n++) send_frame(64'(n), 16, 64'(n + 'h100), 16, n <= 4);
      send_bit(1'b0, 1'b0);
      repeat (6) @(negedge clk);
      chk("ovf_set", overflow, STATUS);
      ready_mode = 1;
      wait_drain("ovf_drain");
      repeat (4) @(negedge clk);
      chk("ovf_empty", out_valid, 0);
      chk("ovf_sticky", overflow, STATUS);
      ready_mode = 0;
      send_frame(64'h7, 16, 64'h8, 16, 0);
      send_frame(64'h9, 16, 64'hA, 16, 0);
      repeat (4) send_bit(1'b0, 1'b1);
      chk("flush_queued", out_valid, 1);
      enable = 1'b0;
      @(negedge clk);
      chk("flush_valid", out_valid, 0);
      chk("flush_ovf", overflow, 0);
      start_group(0);
      send_frame(64'h1111, 16, 64'h2222, 16, 0);
      repeat (6) send_bit(1'b0, 1'b1);
      chk("pre_rst_valid", out_valid, 1);
      #3 rst = 1'b1;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_left", out_left, 0);
      chk("arst_right", out_right, 0);
      chk("arst_ovf", overflow, 0);
      chk("arst_ferr", frame_err, 0);
      @(negedge clk);
      rst = 1'b0;
      ready_mode = 1;
      repeat (4) send_bit(1'b1, 1'b0);
      send_frame(64'hCAFE, 16, 64'hBEEF, 16, 1);
      end_group("post_rst");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
